// File: rtl/expr_pkg.sv
// Shared token, opcode and error encodings plus precedence and BCD sizing helpers.
package expr_pkg;

  localparam int DIGIT_BASE = 10;

  typedef enum logic [1:0] {
    TOK_DIGIT = 2'd0,
    TOK_OP    = 2'd1,
    TOK_EQ    = 2'd2,
    TOK_CLR   = 2'd3
  } tok_type_e;

  typedef enum logic [3:0] {
    OP_ADD  = 4'd0,
    OP_SUB  = 4'd1,
    OP_AND  = 4'd2,
    OP_OR   = 4'd3,
    OP_SLT  = 4'd4,
    OP_LPAR = 4'd5,
    OP_RPAR = 4'd6
  } opcode_e;

  typedef enum logic [1:0] {
    ERR_NONE      = 2'd0,
    ERR_SYNTAX    = 2'd1,
    ERR_STACK     = 2'd2,
    ERR_DIGIT_OVF = 2'd3
  } err_code_e;

  function automatic logic [1:0] prec(input opcode_e op);
    case (op)
      OP_SLT:        prec = 2'd3;
      OP_AND, OP_OR: prec = 2'd2;
      default:       prec = 2'd1;
    endcase
  endfunction

  // ceil(w*log10(2)) digits for the magnitude, plus one spare digit
  function automatic int bcd_digits(input int w);
    return (w * 302 + 999) / 1000 + 1;
  endfunction

endpackage

// File: rtl/expr_eval_core_if.sv
// Token input and result output channels of the expression evaluator.
// EXPR_BCD_OUT_EN adds the BCD magnitude and sign of the result.
interface expr_eval_core_if #(parameter int W = 11);
  import expr_pkg::*;

  logic      tok_valid;
  logic      tok_ready;
  tok_type_e tok_type;
  logic [3:0] tok_val;

  logic         res_valid;
  logic         res_ready;
  logic [W-1:0] res_data;
  logic         res_err;
  err_code_e    err_code;

`ifdef EXPR_BCD_OUT_EN
  logic [4*bcd_digits(W)-1:0] res_bcd;
  logic                       res_neg;

  modport slave (
    input  tok_valid, tok_type, tok_val, res_ready,
    output tok_ready, res_valid, res_data, res_err, err_code, res_bcd, res_neg
  );
  modport master (
    output tok_valid, tok_type, tok_val, res_ready,
    input  tok_ready, res_valid, res_data, res_err, err_code, res_bcd, res_neg
  );
`else
  modport slave (
    input  tok_valid, tok_type, tok_val, res_ready,
    output tok_ready, res_valid, res_data, res_err, err_code
  );
  modport master (
    output tok_valid, tok_type, tok_val, res_ready,
    input  tok_ready, res_valid, res_data, res_err, err_code
  );
`endif

endinterface

// File: rtl/expr_alu.sv
// Purpose: one binary reduction step y = a op b (wrapping add/sub, bitwise and/or, signed less-than).
// Latency: combinational. Backpressure: none.
module expr_alu import expr_pkg::*; #(
  parameter int W = 11
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  opcode_e      op,
  output logic [W-1:0] y
);

  always_comb begin
    y = '0;
    case (op)
      OP_ADD:  y = a + b;
      OP_SUB:  y = a - b;
      OP_AND:  y = a & b;
      OP_OR:   y = a | b;
      OP_SLT:  y = W'($signed(a) < $signed(b));
      default: y = '0;
    endcase
  end

endmodule

// File: rtl/expr_eval_core.sv
// Purpose: token-stream evaluator with precedence/parentheses on two stacks; EXPR_BCD_OUT_EN adds BCD output.
// Latency: one token per cycle in ACCEPT, one reduction per cycle; result 1+N cycles after '=' (+W with BCD).
// Backpressure: tok_ready only in ACCEPT; the result is held in DONE until res_ready.
module expr_eval_core import expr_pkg::*; #(
  parameter int W     = 11,
  parameter int DEPTH = 8
) (
  input  logic            clk,
  input  logic            rst,
  expr_eval_core_if.slave io,
  output logic            busy
);

  localparam int OPW = $clog2(DEPTH + 1);
  localparam int VPW = $clog2(DEPTH + 2);
  localparam int AW  = W + 4;
  localparam logic [AW-1:0] MAX_POS = AW'((1 << (W - 1)) - 1);

`ifdef EXPR_BCD_OUT_EN
  typedef enum logic [2:0] {S_ACCEPT, S_REDUCE, S_FINAL, S_CONVERT, S_DONE} state_e;
`else
  typedef enum logic [1:0] {S_ACCEPT, S_REDUCE, S_FINAL, S_DONE} state_e;
`endif

  state_e state, state_nxt;

  // Stacks sized to the full pointer range so every pointer value is a legal index
  opcode_e      op_stk  [1 << OPW];
  logic [W-1:0] val_stk [1 << VPW];
  logic [OPW-1:0] op_sp;
  logic [VPW-1:0] val_sp;

  logic [W-1:0] acc;
  logic         num_pending, after_rpar, expect_operand, rpar_mode;
  opcode_e      pend_op;

  logic [W-1:0] res_data_q;
  logic         res_valid_q, res_err_q;
  err_code_e    err_code_q, err_nxt;

  logic    take_digit, push_acc, push_op, latch_op, do_reduce, pop_lpar, finish, clear_all;
  opcode_e push_op_val;
  logic    err_set;

  logic           tok_xfer, tok_op_ok, op_full, val_full, operand_ready;
  opcode_e        tok_op, op_top;
  logic [VPW-1:0] vi_a, vi_b;
  logic [AW-1:0]  acc_calc;
  logic [W-1:0]   alu_y;
  logic           red_tok, red_pend;

  assign tok_xfer      = io.tok_valid && (state == S_ACCEPT);
  assign tok_op_ok     = io.tok_val <= 4'd6;
  assign tok_op        = tok_op_ok ? opcode_e'(io.tok_val) : OP_ADD;
  assign op_full       = op_sp == OPW'(DEPTH);
  assign val_full      = val_sp == VPW'(DEPTH + 1);
  assign operand_ready = num_pending || after_rpar;
  assign op_top        = op_stk[op_sp - OPW'(1)];
  assign vi_b          = val_sp - VPW'(1);
  assign vi_a          = val_sp - VPW'(2);
  assign acc_calc      = AW'(acc) * AW'(DIGIT_BASE) + AW'(io.tok_val);
  assign red_tok       = (op_sp != '0) && (op_top != OP_LPAR) && (prec(op_top) >= prec(tok_op));
  assign red_pend      = (op_sp != '0) && (op_top != OP_LPAR) && (prec(op_top) >= prec(pend_op));
  assign err_set       = err_nxt != ERR_NONE;

  expr_alu #(.W(W)) u_alu (.a(val_stk[vi_a]), .b(val_stk[vi_b]), .op(op_top), .y(alu_y));

`ifdef EXPR_BCD_OUT_EN
  localparam int BCD_N = bcd_digits(W);
  localparam int CW    = $clog2(W);
  logic [4*BCD_N-1:0] bcd_sh, bcd_adj;
  logic [W-1:0]       bin_sh;
  logic [CW-1:0]      cnv_cnt;
  logic               res_neg_q, cvt_done;

  always_comb begin
    bcd_adj = bcd_sh;
    for (int i = 0; i < BCD_N; i++)
      if (bcd_sh[4*i +: 4] > 4'd4) bcd_adj[4*i +: 4] = bcd_sh[4*i +: 4] + 4'd3;
  end

  assign io.res_bcd = bcd_sh;
  assign io.res_neg = res_neg_q;
`endif

  always_ff @(posedge clk) begin
    if (rst) state <= S_ACCEPT;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt   = state;
    err_nxt     = ERR_NONE;
    take_digit  = 1'b0;
    push_acc    = 1'b0;
    push_op     = 1'b0;
    push_op_val = pend_op;
    latch_op    = 1'b0;
    do_reduce   = 1'b0;
    pop_lpar    = 1'b0;
    finish      = 1'b0;
    clear_all   = 1'b0;
`ifdef EXPR_BCD_OUT_EN
    cvt_done    = 1'b0;
`endif
    case (state)
      S_ACCEPT: if (tok_xfer) begin
        case (io.tok_type)
          TOK_DIGIT: begin
            if (after_rpar || io.tok_val > 4'd9) err_nxt = ERR_SYNTAX;
            else if (acc_calc > MAX_POS)         err_nxt = ERR_DIGIT_OVF;
            else                                 take_digit = 1'b1;
          end
          TOK_OP: begin
            if (!tok_op_ok) err_nxt = ERR_SYNTAX;
            else if (tok_op == OP_LPAR) begin
              if (!expect_operand || num_pending) err_nxt = ERR_SYNTAX;
              else if (op_full)                   err_nxt = ERR_STACK;
              else begin
                push_op     = 1'b1;
                push_op_val = OP_LPAR;
              end
            end else if (!operand_ready)      err_nxt = ERR_SYNTAX;
            else if (num_pending && val_full) err_nxt = ERR_STACK;
            else begin
              push_acc = num_pending;
              latch_op = 1'b1;
              if (tok_op == OP_RPAR || red_tok) state_nxt = S_REDUCE;
              else if (op_full)                 err_nxt = ERR_STACK;
              else begin
                push_op     = 1'b1;
                push_op_val = tok_op;
              end
            end
          end
          TOK_EQ: begin
            if (!operand_ready)               err_nxt = ERR_SYNTAX;
            else if (num_pending && val_full) err_nxt = ERR_STACK;
            else begin
              push_acc  = num_pending;
              state_nxt = S_FINAL;
            end
          end
          default: clear_all = 1'b1;
        endcase
      end
      S_REDUCE: begin
        if (rpar_mode) begin
          if (op_sp == '0)            err_nxt = ERR_SYNTAX;
          else if (op_top == OP_LPAR) begin
            pop_lpar  = 1'b1;
            state_nxt = S_ACCEPT;
          end else do_reduce = 1'b1;
        end else if (red_pend) do_reduce = 1'b1;
        else if (op_full)      err_nxt = ERR_STACK;
        else begin
          push_op   = 1'b1;
          state_nxt = S_ACCEPT;
        end
      end
      S_FINAL: begin
        if (op_sp == '0) begin
          if (val_sp == VPW'(1)) begin
            finish = 1'b1;
`ifdef EXPR_BCD_OUT_EN
            state_nxt = S_CONVERT;
`else
            state_nxt = S_DONE;
`endif
          end else err_nxt = ERR_SYNTAX;
        end else if (op_top == OP_LPAR) err_nxt = ERR_SYNTAX;
        else do_reduce = 1'b1;
      end
`ifdef EXPR_BCD_OUT_EN
      S_CONVERT: if (cnv_cnt == CW'(W - 1)) begin
        cvt_done  = 1'b1;
        state_nxt = S_DONE;
      end
`endif
      default: if (io.res_ready) begin
        clear_all = 1'b1;
        state_nxt = S_ACCEPT;
      end
    endcase
    // A reduction needs two operands; fewer means the token stream was malformed
    if (do_reduce && val_sp < VPW'(2)) err_nxt = ERR_SYNTAX;
    if (err_nxt != ERR_NONE) begin
      state_nxt  = S_DONE;
      take_digit = 1'b0;
      push_acc   = 1'b0;
      push_op    = 1'b0;
      latch_op   = 1'b0;
      do_reduce  = 1'b0;
      pop_lpar   = 1'b0;
      finish     = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (push_acc)  val_stk[val_sp] <= acc;
    if (do_reduce) val_stk[vi_a]   <= alu_y;
    if (push_op)   op_stk[op_sp]   <= push_op_val;
  end

  always_ff @(posedge clk) begin
    if (rst || clear_all) begin
      op_sp          <= '0;
      val_sp         <= '0;
      acc            <= '0;
      num_pending    <= 1'b0;
      after_rpar     <= 1'b0;
      expect_operand <= 1'b1;
      rpar_mode      <= 1'b0;
      pend_op        <= OP_ADD;
      res_valid_q    <= 1'b0;
      res_err_q      <= 1'b0;
      err_code_q     <= ERR_NONE;
      res_data_q     <= '0;
`ifdef EXPR_BCD_OUT_EN
      bcd_sh         <= '0;
      bin_sh         <= '0;
      cnv_cnt        <= '0;
      res_neg_q      <= 1'b0;
`endif
    end else begin
      if (take_digit) begin
        acc            <= acc_calc[W-1:0];
        num_pending    <= 1'b1;
        expect_operand <= 1'b0;
      end
      if (push_acc) begin
        acc         <= '0;
        num_pending <= 1'b0;
        val_sp      <= val_sp + VPW'(1);
      end
      if (latch_op) begin
        pend_op        <= tok_op;
        rpar_mode      <= tok_op == OP_RPAR;
        after_rpar     <= 1'b0;
        expect_operand <= tok_op != OP_RPAR;
      end
      if (push_op) op_sp <= op_sp + OPW'(1);
      if (pop_lpar) begin
        op_sp      <= op_sp - OPW'(1);
        after_rpar <= 1'b1;
        rpar_mode  <= 1'b0;
      end
      if (do_reduce) begin
        op_sp  <= op_sp - OPW'(1);
        val_sp <= val_sp - VPW'(1);
      end
      if (finish) begin
        res_data_q <= val_stk[0];
`ifdef EXPR_BCD_OUT_EN
        bin_sh    <= val_stk[0][W-1] ? -val_stk[0] : val_stk[0];
        res_neg_q <= val_stk[0][W-1];
        bcd_sh    <= '0;
        cnv_cnt   <= '0;
`else
        res_valid_q <= 1'b1;
`endif
      end
`ifdef EXPR_BCD_OUT_EN
      if (state == S_CONVERT) begin
        {bcd_sh, bin_sh} <= {bcd_adj, bin_sh} << 1;
        cnv_cnt          <= cnv_cnt + CW'(1);
      end
      if (cvt_done) res_valid_q <= 1'b1;
`endif
      if (err_set) begin
        res_valid_q <= 1'b1;
        res_err_q   <= 1'b1;
        err_code_q  <= err_nxt;
        res_data_q  <= '0;
`ifdef EXPR_BCD_OUT_EN
        bcd_sh      <= '0;
        res_neg_q   <= 1'b0;
`endif
      end
    end
  end

  assign io.tok_ready = state == S_ACCEPT;
  assign io.res_valid = res_valid_q;
  assign io.res_data  = res_data_q;
  assign io.res_err   = res_err_q;
  assign io.err_code  = err_code_q;
  assign busy         = state != S_ACCEPT;

endmodule

// File: doc/expr_eval_core.md
Name: expr_eval_core

Overview:
Parametrised expression evaluator: the successor to the keypad calculator's priority-stack engine. It takes a token stream (digits, operators, parentheses, equals, clear) over a valid/ready handshake and builds decimal operands. Evaluation uses operator and operand stacks with precedence and parentheses. A signed two's-complement result, or an error code, is delivered on a valid/ready output channel. It sits between keypad decode and the display formatter.

Parameters:
W, 11, operand/result width in bits (signed two's complement)
DEPTH, 8, operator stack depth; operand stack depth is DEPTH+1

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
tok_valid  in  1  token present
tok_ready  out  1  core accepts token this cycle
tok_type  in  2  DIGIT=0, OP=1, EQ=2, CLR=3
tok_val  in  4  digit 0-9, or opcode when OP
res_valid  out  1  result/error present
res_ready  in  1  consumer takes result
res_data  out  W  signed result
res_err  out  1  result is an error
err_code  out  2  NONE=0, SYNTAX=1, STACK=2, DIGIT_OVF=3
busy  out  1  state != ACCEPT

Behaviour:
- Opcodes: ADD=0, SUB=1, AND=2, OR=3, SLT=4, LPAR=5, RPAR=6. Any other OP value -> SYNTAX error.
- Precedence: SLT=3 > AND/OR=2 > ADD/SUB=1. All operators are left-associative. ADD/SUB wrap modulo 2^W. SLT gives 1 if a<b signed, else 0. AND/OR are bitwise.
- Reset: state=ACCEPT, stacks empty, acc=0, expect_operand=1, res_valid=0, res_err=0, err_code=0, res_data=0, tok_ready=1.
- FSM states: ACCEPT, REDUCE, FINAL, DONE. tok_ready=1 only in ACCEPT. A transfer happens when tok_valid&&tok_ready.
- DIGIT:
  - acc <= acc*10+d; sets num_pending. One cycle.
  - If the unsigned result exceeds 2^(W-1)-1 -> DIGIT_OVF.
  - A digit arriving right after RPAR -> SYNTAX.
- Binary OP:
  - Requires num_pending or a just-closed RPAR; otherwise SYNTAX.
  - Pushes acc (if pending) and latches the new op into pend_op.
  - If the top op is not LPAR and prec(top) >= prec(pend_op) -> REDUCE; else push pend_op and stay in ACCEPT.
- REDUCE: exactly one reduction per cycle (pop b, pop a, pop op, push a op b). Re-test the condition each cycle, then push pend_op and return to ACCEPT.
- LPAR:
  - Allowed only when expect_operand and not num_pending; otherwise SYNTAX.
  - Pushes LPAR.
- RPAR:
  - Pushes the pending operand, then reduces until the top is LPAR, one per cycle, and pops it.
  - An empty op stack with no LPAR -> SYNTAX.
- EQ:
  - Pushes the pending operand and enters FINAL.
  - FINAL reduces one op per cycle until the op stack is empty.
  - Meeting an LPAR in FINAL -> SYNTAX.
  - Then DONE: res_data = sole operand.
  - Latency: EQ accepted at cycle t gives res_valid at t+1+N, where N = ops on the stack.
- DONE:
  - res_valid is held stable until res_ready.
  - On handshake: res_valid=0, stacks cleared, go to ACCEPT.
  - The result persists unchanged while res_ready=0.
- Errors:
  - Any error goes to DONE with res_err=1, err_code set, res_data=0.
  - Remaining tokens are not consumed until the handshake completes.
- Stack overflow (push into a full op stack or operand stack) -> STACK error; the push is not performed.
- CLR (ACCEPT only): clears stacks, acc, pend_op and flags. No result is produced.
- rst in any state, including mid-REDUCE/FINAL: immediate return to the reset values; any in-flight result is discarded.

Optional Feature:
EXPR_BCD_OUT_EN
- Defined:
  - Adds ports res_bcd [4*ceil(W*0.302)+4-1:0] (magnitude BCD digits) and res_neg.
  - Adds state CONVERT between FINAL and DONE, running a shift-add-3 conversion for exactly W cycles.
  - res_valid latency grows by W.
  - Error results skip conversion; res_bcd=0, res_neg=0.
- Undefined: no extra ports or state; latency as above.

Decomposition:
- Package expr_pkg:
  - tok_type_e and opcode_e enums
  - err_code_e
  - prec() function
  - DIGIT_BASE=10
  - BCD digit-count function
- Sub-module expr_alu (combinational a, b, op -> y), instantiated once in the reduce path.

Test Plan:
- "12+3=" -> res_valid with res_data=15, res_err=0. Hold res_ready=0 for 5 cycles -> value stable.
- "2+3&6=" -> 3&6=2, then 2+2 -> res_data=4. Exactly 2 reduce cycles after EQ before res_valid.
- "5-9=" with W=11 -> res_data=11'h7FC (-4). "3<5+1=" -> res_data=2.
- "(1+2)&6=" -> 2. "1+2)=" -> SYNTAX. "(1=" -> SYNTAX.
- DEPTH=4, "((((( " -> STACK on the 5th LPAR. Then CLR, then "7=" -> 7. Digits "9999" with W=11 -> DIGIT_OVF.
- rst asserted mid-FINAL -> next cycle busy=0, res_valid=0. A subsequent "4+4=" -> 8.
